// File: rtl/poly_result_streamer_pkg.sv
// poly_result_pkg: shared constants, size derivations, FSM state type and
// word-level helpers for the poly_mult result streamer.
//   calc_n_mem / calc_words / calc_tail_bits : geometry of the padded result
//   byte_rearrange : byte k of the output takes byte (nbytes-1-k) of the input
//   tail_mask      : ones in bit positions [tail-1:0]
package poly_result_pkg;

    localparam int MAXW     = 64;     // widest word the helpers handle
    localparam int N_HQC128 = 17669;
    localparam int RAMWIDTH = 32;

    function automatic int calc_n_mem(input int n, input int w);
        return ((n + w - 1) / w) * w;
    endfunction

    function automatic int calc_words(input int n, input int w);
        return calc_n_mem(n, w) / w;
    endfunction

    function automatic int calc_tail_bits(input int n, input int w);
        return n - (calc_words(n, w) - 1) * w;
    endfunction

    localparam int N_MEM     = calc_n_mem(N_HQC128, RAMWIDTH);
    localparam int WORDS     = calc_words(N_HQC128, RAMWIDTH);
    localparam int TAIL_BITS = calc_tail_bits(N_HQC128, RAMWIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Byte-order reversal inside the low nbytes bytes; upper bytes are zero.
    function automatic logic [MAXW-1:0] byte_rearrange(input logic [MAXW-1:0] w,
                                                       input int nbytes);
        logic [MAXW-1:0] r;
        r = '0;
        for (int k = 0; k < MAXW / 8; k++) begin
            if (k < nbytes) begin
                r[8*k +: 8] = w[8*(nbytes-1-k) +: 8];
            end else begin
                r[8*k +: 8] = 8'h00;
            end
        end
        return r;
    endfunction

    // Keeps the valid polynomial bits of the last word.
    function automatic logic [MAXW-1:0] tail_mask(input int tail);
        logic [MAXW-1:0] m;
        m = '0;
        for (int i = 0; i < MAXW; i++) begin
            m[i] = (i < tail) ? 1'b1 : 1'b0;
        end
        return m;
    endfunction

endpackage

// File: rtl/poly_result_streamer_if.sv
// Output stream interface of the result streamer.
//   m_data  : rearranged, masked result word
//   m_valid : m_data valid
//   m_ready : sink accepts; transfer when m_valid && m_ready
//   m_last  : marks the final word of a run
// master = streamer side, slave = consumer side.
interface poly_result_streamer_if #(
    parameter int RAMWIDTH = poly_result_pkg::RAMWIDTH
) ();
    logic [RAMWIDTH-1:0] m_data;
    logic                m_valid;
    logic                m_ready;
    logic                m_last;

    modport master (output m_data, output m_valid, output m_last, input m_ready);
    modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/poly_result_streamer_result_fifo2.sv
// result_fifo2: two-entry registered FIFO. The head entry is always held in
// head_r so the consumer sees a register, not a read mux.
//   clk, rst_n : clock, async active-low reset
//   push, push_data : write request and entry
//   pop        : remove head (ignored when empty)
//   head       : current head entry (zero when empty)
//   count      : occupancy 0..2
module result_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);
    logic [W-1:0] head_r;
    logic [W-1:0] tail_r;
    logic [1:0]   count_r;
    logic         pop_ok_s;
    logic         push_ok_s;

    assign pop_ok_s  = pop && (count_r != 2'd0);
    // A full FIFO can still take a word in the cycle its head leaves.
    assign push_ok_s = push && ((count_r != 2'd2) || pop_ok_s);
    assign head      = head_r;
    assign count     = count_r;

    // Shift-register storage update and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b11: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end else begin
                        head_r <= push_data;
                    end
                end
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    if (count_r == 2'd2) begin
                        head_r <= tail_r;
                        tail_r <= '0;
                    end else begin
                        head_r <= '0;
                    end
                    count_r <= count_r - 2'd1;
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end
endmodule

// File: rtl/poly_result_streamer.sv
// poly_result_streamer: reads the finished poly_mult product word by word,
// masks the padding above bit N-1, reverses byte order inside each word and
// streams the words out on a valid/ready interface.
//   clk, rst_n   : clock, async active-low reset
//   start        : run request (accepted only in IDLE and not while done)
//   busy, done   : run in progress / one-cycle completion pulse
//   addr_result, rd_dout, dout : result memory read port (1-cycle latency)
//   m_if         : output stream (master)
module poly_result_streamer #(
    parameter int N          = poly_result_pkg::N_HQC128,
    parameter int RAMWIDTH   = poly_result_pkg::RAMWIDTH,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] addr_result,
    output logic                  rd_dout,
    input  logic [RAMWIDTH-1:0]   dout,
    poly_result_streamer_if.master m_if
);
    import poly_result_pkg::*;

    localparam int W_WORDS = calc_words(N, RAMWIDTH);
    localparam int W_TAIL  = calc_tail_bits(N, RAMWIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(W_WORDS - 1);
    localparam logic [RAMWIDTH-1:0]   TAIL_MASK = RAMWIDTH'(tail_mask(W_TAIL));

    state_t                state_r, state_next_s;
    logic [ADDR_WIDTH-1:0] idx_r, idx_next_s;
    logic                  inflight_r;
    logic                  cap_last_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  rd_s;
    logic                  pop_s;
    logic                  credit_ok_s;
    logic [1:0]            count_s;
    logic [RAMWIDTH:0]     head_s;
    logic [RAMWIDTH-1:0]   masked_s;
    logic [RAMWIDTH:0]     push_data_s;

    assign m_if.m_valid = (count_s != 2'd0);
    assign m_if.m_data  = head_s[RAMWIDTH-1:0];
    assign m_if.m_last  = head_s[RAMWIDTH];
    assign pop_s        = m_if.m_valid && m_if.m_ready;
    assign busy         = busy_r;
    assign done         = done_r;
    assign rd_dout      = rd_s;
    assign addr_result  = idx_r;

    // Words held plus the word still in flight, less the one leaving now,
    // must stay below the buffer depth so every returned word has a slot.
    assign credit_ok_s = (({1'b0, count_s} + {2'b00, inflight_r}) <
                          (3'd2 + {2'b00, pop_s}));

    // FSM next state, read strobe and index update.
    always_comb begin
        state_next_s = state_r;
        idx_next_s   = idx_r;
        rd_s         = 1'b0;
        case (state_r)
            IDLE: begin
                // The done cycle is still IDLE; a start there is ignored.
                if (start && !done_r) begin
                    state_next_s = RUN;
                    idx_next_s   = '0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            RUN: begin
                if (credit_ok_s) begin
                    rd_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_next_s = DRAIN;
                    end else begin
                        idx_next_s = idx_r + ADDR_WIDTH'(1);
                    end
                end else begin
                    rd_s = 1'b0;
                end
            end
            DRAIN: begin
                if (pop_s && m_if.m_last) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, index, read pipeline and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= '0;
            inflight_r <= 1'b0;
            cap_last_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            idx_r      <= idx_next_s;
            inflight_r <= rd_s;
            cap_last_r <= rd_s && (idx_r == LAST_IDX);
            busy_r     <= (state_next_s != IDLE);
            done_r     <= (state_r == DRAIN) && pop_s && m_if.m_last;
        end
    end

    // Mask padding in the last word, then reorder bytes for the FIFO.
    always_comb begin
        masked_s = dout;
        if (cap_last_r) begin
            masked_s = dout & TAIL_MASK;
        end else begin
            masked_s = dout;
        end
        push_data_s = {cap_last_r,
                       RAMWIDTH'(byte_rearrange(MAXW'(masked_s), RAMWIDTH / 8))};
    end

    result_fifo2 #(.W(RAMWIDTH + 1)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_r),
        .push_data (push_data_s),
        .pop       (pop_s),
        .head      (head_s),
        .count     (count_s)
    );
endmodule

// File: tb/tb_poly_result_streamer.sv
module tb_poly_result_streamer;
    localparam int WORDS_TB = 553;

    logic        clk = 1'b0;
    logic        rst_n;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    // hqc128 instance
    logic        start_a, busy_a, done_a, rd_a;
    logic [9:0]  addr_a;
    logic [31:0] dout_a;
    bit          mode_ones = 1'b0;
    bit          rand_rdy = 1'b0;
    poly_result_streamer_if #(.RAMWIDTH(32)) ifa ();

    // N=31 instance
    logic        start_b, busy_b, done_b, rd_b;
    logic [3:0]  addr_b;
    logic [31:0] dout_b;
    poly_result_streamer_if #(.RAMWIDTH(32)) ifb ();

    logic [32:0] exp_q[$];
    int          next_rd, issued, xfer, done_cnt, done_cyc, last_cyc, start_cyc;
    logic        busy_at_done;
    logic [31:0] last_data;
    logic        stall_prev;
    logic [32:0] prev_word;

    poly_result_streamer #(.N(17669), .RAMWIDTH(32), .ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a),
        .addr_result(addr_a), .rd_dout(rd_a), .dout(dout_a), .m_if(ifa));

    poly_result_streamer #(.N(31), .RAMWIDTH(32), .ADDR_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b),
        .addr_result(addr_b), .rd_dout(rd_b), .dout(dout_b), .m_if(ifb));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Result memory models: word i = i, or all ones; one-cycle read latency.
    always @(posedge clk) begin
        if (rd_a) dout_a <= mode_ones ? 32'hFFFF_FFFF : {22'd0, addr_a};
        if (rd_b) dout_b <= 32'hFFFF_FFFF;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int j, input bit ones);
        logic [31:0] w;
        w = ones ? 32'hFFFF_FFFF : 32'(j);
        if (j == WORDS_TB - 1) w = w & 32'h0000_001F;
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Sink ready: held high or toggled randomly, changed just after the edge.
    initial begin
        ifa.m_ready = 1'b1;
        ifb.m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            ifa.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor / scoreboard on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev)
                check("stall_stable", {31'd0, ifa.m_valid, ifa.m_last, ifa.m_data},
                      {31'd0, 1'b1, prev_word});
            if (rd_a) begin
                check("rd_addr", 64'(addr_a), 64'(next_rd));
                next_rd++;
                issued++;
            end
            if (ifa.m_valid && ifa.m_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", 64'(exp_q.size()), 64'd1);
                end else begin
                    check("word", {31'd0, ifa.m_last, ifa.m_data}, 64'(exp_q.pop_front()));
                    xfer++;
                    if (ifa.m_last) begin
                        last_cyc  = cyc;
                        last_data = ifa.m_data;
                    end
                end
            end
            if (rd_a) check("outstanding_le2", 64'((issued - xfer) <= 2), 64'd1);
            if (done_a) begin
                done_cnt++;
                done_cyc     = cyc;
                busy_at_done = busy_a;
            end
            stall_prev = ifa.m_valid && !ifa.m_ready;
            prev_word  = {ifa.m_last, ifa.m_data};
        end
    end

    // Called #1 after a rising edge; returns #1 after the next one (cycle 1).
    task automatic run_start(input bit ones);
        mode_ones = ones;
        for (int j = 0; j < WORDS_TB; j++) exp_q.push_back({(j == WORDS_TB - 1), exp_word(j, ones)});
        next_rd = 0; issued = 0; xfer = 0; last_cyc = -1; done_cyc = -1;
        start_cyc = cyc;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int i = 0;
        while (done_cnt == d0 && i < budget) begin
            @(posedge clk); #1;
            i++;
        end
        check("done_once", 64'(done_cnt), 64'(d0 + 1));
        check("words_out", 64'(xfer), 64'(WORDS_TB));
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("busy_at_done", 64'(busy_at_done), 64'd0);
    endtask

    initial begin
        int d0;
        rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; done_cnt = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  64'(busy_a),      64'd0);
        check("rst_done",  64'(done_a),      64'd0);
        check("rst_rd",    64'(rd_a),        64'd0);
        check("rst_addr",  64'(addr_a),      64'd0);
        check("rst_valid", 64'(ifa.m_valid), 64'd0);
        check("rst_last",  64'(ifa.m_last),  64'd0);
        check("rst_data",  64'(ifa.m_data),  64'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Nominal: word i = i, ready always high.
        run_start(1'b0);
        check("c1_busy", 64'(busy_a), 64'd1);
        check("c1_rd",   64'(rd_a),   64'd1);
        check("c1_addr", 64'(addr_a), 64'd0);
        wait_done(2000);
        check("nom_done_cyc", 64'(done_cyc - start_cyc), 64'd556);
        check("nom_last_cyc", 64'(last_cyc - start_cyc), 64'd555);
        repeat (2) @(posedge clk); #1;

        // All-ones memory: padding cleared in the last word.
        run_start(1'b1);
        wait_done(2000);
        check("ones_last", 64'(last_data), 64'h1F00_0000);
        repeat (2) @(posedge clk); #1;

        // Random backpressure.
        rand_rdy = 1'b1;
        run_start(1'b0);
        wait_done(6000);
        rand_rdy = 1'b0;
        repeat (3) @(posedge clk); #1;

        // start pulsed at cycle 100 of a run is ignored.
        run_start(1'b0);
        repeat (99) @(posedge clk);
        #1; start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        wait_done(2000);
        check("restart_done_cyc", 64'(done_cyc - start_cyc), 64'd556);
        repeat (2) @(posedge clk); #1;

        // start coincident with done is ignored.
        run_start(1'b0);
        repeat (555) @(posedge clk);
        #1;
        check("done_cycle_now", 64'(done_a), 64'd1);
        start_a = 1'b1;
        @(posedge clk); #1; start_a = 1'b0;
        check("start_at_done_busy", 64'(busy_a), 64'd0);
        check("start_at_done_cnt", 64'(xfer), 64'(WORDS_TB));
        repeat (3) @(posedge clk); #1;
        check("start_at_done_idle", 64'(busy_a), 64'd0);

        // Reset at word 200 aborts; next run starts from word 0.
        run_start(1'b0);
        begin
            int i = 0;
            while (xfer < 200 && i < 1000) begin
                @(posedge clk); #1;
                i++;
            end
        end
        check("reached_word200", 64'(xfer), 64'd200);
        d0 = done_cnt;
        #1 rst_n = 1'b0;
        #1;
        check("arst_busy",  64'(busy_a),      64'd0);
        check("arst_rd",    64'(rd_a),        64'd0);
        check("arst_addr",  64'(addr_a),      64'd0);
        check("arst_valid", 64'(ifa.m_valid), 64'd0);
        check("arst_last",  64'(ifa.m_last),  64'd0);
        check("arst_data",  64'(ifa.m_data),  64'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk); #1;
        check("arst_no_done", 64'(done_cnt), 64'(d0));
        run_start(1'b0);
        check("after_rst_addr", 64'(addr_a), 64'd0);
        wait_done(2000);
        check("after_rst_done_cyc", 64'(done_cyc - start_cyc), 64'd556);
        repeat (2) @(posedge clk); #1;

        // Small configuration N=31: one word, done at cycle 4.
        start_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        check("b_c1_rd", 64'(rd_b), 64'd1);
        check("b_c1_busy", 64'(busy_b), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b_c3_valid", 64'(ifb.m_valid), 64'd1);
        check("b_c3_data",  64'(ifb.m_data),  64'hFFFF_FF7F);
        check("b_c3_last",  64'(ifb.m_last),  64'd1);
        @(posedge clk); #1;
        check("b_c4_done",  64'(done_b), 64'd1);
        check("b_c4_busy",  64'(busy_b), 64'd0);
        check("b_c4_valid", 64'(ifb.m_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/poly_result_streamer.md
# poly_result_streamer

Reads the finished product out of `poly_mult` once it asserts `valid`. Walks the result memory through `addr_result`/`rd_dout` and zeroes the padding bits above bit N-1 in the last word. Applies the byte rearrangement required for HQC byte-serial output and streams one word per cycle over a valid/ready interface. Sits directly downstream of `poly_mult` and replaces the bench-side readout loop in the integrated design.

## Interface
- `N`, 17669: polynomial length in bits (hqc128).
- `RAMWIDTH`, 32: result word width; multiple of 8.
- `N_MEM`, N rounded up to a multiple of RAMWIDTH: padded length.
- `WORDS`, N_MEM/RAMWIDTH (553): words streamed per run.
- `ADDR_WIDTH`, CLOG2 of the poly_mult RAMSIZE: result address width.
- `TAIL_BITS`, N - (WORDS-1)*RAMWIDTH (5): valid bits in the last word.

Ports:
- `clk`  in  1  system clock, all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse, driven from the rising edge of poly_mult `valid`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last output handshake.
- `addr_result`  out  ADDR_WIDTH  result word address to poly_mult.
- `rd_dout`  out  1  read strobe to poly_mult.
- `dout`  in  RAMWIDTH  poly_mult result word, valid exactly 1 cycle after the `rd_dout` cycle.
- `m_data`  out  RAMWIDTH  rearranged, masked word.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts; a transfer occurs when `m_valid && m_ready`.
- `m_last`  out  1  high with word WORDS-1.

## Operation
- States:
  - IDLE: `start` moves to RUN, and the read index is cleared.
  - RUN: issues reads 0..WORDS-1, then goes to DRAIN.
  - DRAIN: waits for the 2-entry output buffer to empty and the final handshake, pulses `done`, returns to IDLE.
- `start` outside IDLE is ignored.
- Read issue: in RUN, `rd_dout`=1 and `addr_result`=index when (buffer occupancy + reads in flight - pop this cycle) < 2. Otherwise `rd_dout`=0 and `addr_result` holds.
- Credit rule: the buffer never overflows, and `dout` is never lost under any `m_ready` pattern.
- Capture: the word returned one cycle after the read is pushed with its index.
- Masking: a word with index WORDS-1 has bits [RAMWIDTH-1:TAIL_BITS] forced to 0. Polynomial bit i is at word i/RAMWIDTH, bit i%RAMWIDTH. Masking is applied before rearrangement.
- Rearrangement: out[8k+7:8k] = in[RAMWIDTH-1-8k : RAMWIDTH-8-8k], for k = 0..RAMWIDTH/8-1.
- Output: `m_data`/`m_last` are driven from the buffer head register. They are stable while `m_valid && !m_ready`.
- Reset values: `busy`, `done`, `rd_dout`, `m_valid`, `m_last` = 0; `addr_result` = 0; `m_data` = 0. State returns to IDLE and the buffer is emptied.
- Reset mid-run aborts immediately. No `done` is produced, and the next `start` restarts from word 0.

## Timing
- Cycle 0: `start`=1.
- Cycle 1: `busy`=1, `rd_dout`=1, `addr_result`=0.
- Cycle 2: `dout` carries word 0 and is pushed.
- Cycle 3: `m_valid`=1 with word 0.
- With `m_ready` held high, one word transfers per cycle. Word j is output in cycle 3+j, and `m_last` is in cycle 3+WORDS-1 (555 for hqc128).
- `done`=1 and `busy`=0 in cycle 3+WORDS; total 556 cycles for hqc128.
- After `m_ready` returns high following a stall, output resumes the next cycle with no bubble beyond one read latency.
- A `start` in the same cycle as `done` is ignored. `start` is accepted from the cycle after `done`.

## Structure
- Package `poly_result_pkg`: RAMWIDTH, WORDS, TAIL_BITS, N_MEM derivation, state enum (IDLE/RUN/DRAIN), function `byte_rearrange` and function `tail_mask`.
- Sub-module `result_fifo2`: 2-entry registered FIFO carrying {last, data}, with push/pop, `count[1:0]`, and async active-low reset.
- Top level holds the FSM, read index counter (ADDR_WIDTH bits, stops at WORDS-1), in-flight flag, and credit logic.

## Test plan
- Nominal hqc128, poly_mult memory loaded with word i = i, `m_ready`=1 -> 553 words; word j = byte_rearrange(j); `done` at cycle 556 after `start`.
- All-ones memory -> the first 552 outputs are 0xFFFFFFFF. The last output is 0x1F000000 with `m_last`=1.
- Random `m_ready` (50% duty) -> same ordered sequence as the nominal case. No drop or duplicate, `m_data` stable during stalls, at most 2 reads outstanding.
- `start` pulsed at cycle 100 of a run -> ignored; exactly 553 words and one `done`.
- `rst_n` low at word 200 -> all outputs 0 asynchronously. The next `start` streams from word 0 and completes normally.
- Small set N=31, RAMWIDTH=32, memory 0xFFFFFFFF -> single word 0xFFFFFF7F with `m_last`=1, `done` at cycle 4.
